// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - modular exponentiation engine, right-to-left square-and-multiply
//
// Computes r = m^e mod n with a bit-serial interleaved modular multiplier
// (one multiplier bit per cycle, BITS cycles per multiply).
//
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   synchronous active-high reset
//   START  in   begin an operation; honoured only in IDLE or DONE
//   m      in   base, unsigned, BITS wide
//   e      in   exponent, unsigned, BITS wide
//   n      in   modulus, unsigned, BITS wide
//   r      out  result m^e mod n, held while done is high
//   done   out  level, r/err valid
//   busy   out  operation in progress
//   err    out  illegal operands (n <= 1 or m >= n), valid with done

module mod_exp_engine #(
    parameter int BITS = 128
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [BITS-1:0] m,
    input  logic [BITS-1:0] e,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] r,
    output logic            done,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        SQR,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [BITS-1:0] base_q;    // squared each round; also the multiplicand of every multiply
    logic [BITS-1:0] exp_q;     // remaining exponent, consumed LSB first
    logic [BITS-1:0] mod_q;
    logic [BITS-1:0] acc_q;
    logic [BITS-1:0] mul_a_q;   // multiplier, shifted out MSB first
    logic [BITS+1:0] p_q;       // partial product, always < n between cycles
    logic [CW-1:0]   cnt_q;

    logic [BITS+1:0] mod_w;
    logic [BITS+1:0] p_sum;
    logic [BITS+1:0] p_r1;
    logic [BITS+1:0] p_next;
    logic [BITS-1:0] prod;
    logic            mul_last;
    logic            rest_zero;
    logic            illegal;

    // One interleaved step: 2P + b stays below 3n, so at most two
    // subtractions bring it back under n and BITS+2 bits never overflow.
    always_comb begin
        mod_w  = {2'b00, mod_q};
        p_sum  = (p_q << 1) + (mul_a_q[BITS-1] ? {2'b00, base_q} : '0);
        p_r1   = (p_sum >= mod_w) ? (p_sum - mod_w) : p_sum;
        p_next = (p_r1 >= mod_w) ? (p_r1 - mod_w) : p_r1;
        prod   = p_next[BITS-1:0];
    end

    assign mul_last  = (cnt_q == CW'(BITS - 1));
    assign rest_zero = (exp_q[BITS-1:1] == '0);
    assign illegal   = (mod_q <= BITS'(1)) || (base_q >= mod_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) state_d = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (illegal || (exp_q == '0)) state_d = DONE;
                else if (exp_q[0])            state_d = MUL;
                else                          state_d = SQR;
            end
            MUL: begin
                busy = 1'b1;
                if (mul_last) state_d = rest_zero ? DONE : SQR;
            end
            SQR: begin
                busy = 1'b1;
                // exp_q[1] is the bit that becomes current after this square's shift
                if (mul_last) state_d = exp_q[1] ? MUL : SQR;
            end
            DONE: begin
                done = 1'b1;
                if (START) state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r       <= '0;
            err     <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            acc_q   <= '0;
            mul_a_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (START) begin
                        base_q <= m;
                        exp_q  <= e;
                        mod_q  <= n;
                        err    <= 1'b0;
                    end
                end
                CHECK: begin
                    acc_q   <= BITS'(1);
                    p_q     <= '0;
                    cnt_q   <= '0;
                    mul_a_q <= exp_q[0] ? BITS'(1) : base_q;
                    if (illegal) begin
                        r   <= '0;
                        err <= 1'b1;
                    end else if (exp_q == '0) begin
                        r <= BITS'(1);
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        acc_q   <= prod;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        mul_a_q <= base_q;
                        if (rest_zero) r <= prod;
                    end else begin
                        p_q     <= p_next;
                        cnt_q   <= cnt_q + 1'b1;
                        mul_a_q <= mul_a_q << 1;
                    end
                end
                SQR: begin
                    if (mul_last) begin
                        base_q  <= prod;
                        exp_q   <= exp_q >> 1;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        mul_a_q <= exp_q[1] ? acc_q : prod;
                    end else begin
                        p_q     <= p_next;
                        cnt_q   <= cnt_q + 1'b1;
                        mul_a_q <= mul_a_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb/tb_mod_exp_engine.sv - directed self-checking bench for mod_exp_engine (BITS=128 and BITS=8)
//
// Latency is counted in rising edges: the edge that samples START is 1,
// and the count stops at the first edge after which done reads high.

module tb_mod_exp_engine;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         s128, s8;
    logic [127:0] m128, e128, n128;
    logic [127:0] r128;
    logic         done128, busy128, err128;
    logic [7:0]   m8, e8, n8;
    logic [7:0]   r8;
    logic         done8, busy8, err8;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mod_exp_engine #(.BITS(128)) dut128 (
        .CLK(CLK), .RESET(RESET), .START(s128),
        .m(m128), .e(e128), .n(n128),
        .r(r128), .done(done128), .busy(busy128), .err(err128)
    );

    mod_exp_engine #(.BITS(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .START(s8),
        .m(m8), .e(e8), .n(n8),
        .r(r8), .done(done8), .busy(busy8), .err(err8)
    );

    // ok is cleared if done was high or busy low on any sample before completion
    task automatic run128(input logic [127:0] mi, input logic [127:0] ei, input logic [127:0] ni,
                          output int lat, output bit tmo, output bit ok);
        m128 = mi; e128 = ei; n128 = ni; s128 = 1'b1;
        @(posedge CLK); #1;
        s128 = 1'b0;
        lat = 1; tmo = 1'b0; ok = 1'b1;
        while (!done128) begin
            if (!busy128) ok = 1'b0;
            if (lat >= 3000) begin tmo = 1'b1; break; end
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] mi, input logic [7:0] ei, input logic [7:0] ni,
                        output int lat, output bit tmo, output bit ok);
        m8 = mi; e8 = ei; n8 = ni; s8 = 1'b1;
        @(posedge CLK); #1;
        s8 = 1'b0;
        lat = 1; tmo = 1'b0; ok = 1'b1;
        while (!done8) begin
            if (!busy8) ok = 1'b0;
            if (lat >= 3000) begin tmo = 1'b1; break; end
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; s8 = 1'b1; s128 = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0; s8 = 1'b0; s128 = 1'b0;
        checks++;
        if ({r8, done8, busy8, err8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: r=%0d done=%b busy=%b err=%b, want all 0", r8, done8, busy8, err8);
        end
        checks++;
        if (r128 !== 128'd0 || done128 !== 1'b0 || busy128 !== 1'b0 || err128 !== 1'b0) begin
            errors++;
            $display("FAIL reset128: r=%0d done=%b busy=%b err=%b, want all 0", r128, done128, busy128, err128);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy8 !== 1'b0 || busy128 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates_start: busy8=%b busy128=%b, want 0", busy8, busy128);
        end
    endtask

    task automatic test_rsa128;
        logic [127:0] tm [3] = '{128'd65, 128'd2790, 128'd0};
        logic [127:0] te [3] = '{128'd17, 128'd2753, 128'd5};
        logic [127:0] tr [3] = '{128'd2790, 128'd65, 128'd0};
        int           tl [3] = '{770, 2050, 514};
        int  lat;
        bit  tmo, ok;
        for (int i = 0; i < 3; i++) begin
            run128(tm[i], te[i], 128'd3233, lat, tmo, ok);
            checks++;
            if (tmo) begin errors++; $display("FAIL rsa128[%0d] timeout: done never rose", i); end
            checks++;
            if (r128 !== tr[i] || err128 !== 1'b0) begin
                errors++;
                $display("FAIL rsa128[%0d] result: r=%0d err=%b, want r=%0d err=0", i, r128, err128, tr[i]);
            end
            checks++;
            if (lat !== tl[i]) begin
                errors++;
                $display("FAIL rsa128[%0d] latency: got %0d, want %0d", i, lat, tl[i]);
            end
            checks++;
            if (!ok || busy128 !== 1'b0) begin
                errors++;
                $display("FAIL rsa128[%0d] busy/done: during_ok=%b busy_at_done=%b, want 1/0", i, ok, busy128);
            end
        end
    endtask

    task automatic test_vectors8;
        // m, e, n, r, err, latency
        logic [7:0] tm [7] = '{8'd4,   8'd4,  8'd4,  8'd252, 8'd0,  8'd253, 8'd7};
        logic [7:0] te [7] = '{8'd13,  8'd1,  8'd0,  8'd2,   8'd3,  8'd5,   8'd0};
        logic [7:0] tn [7] = '{8'd253, 8'd253, 8'd253, 8'd253, 8'd1, 8'd253, 8'd0};
        logic [7:0] tr [7] = '{8'd108, 8'd4,  8'd1,  8'd1,   8'd0,  8'd0,   8'd0};
        logic       tx [7] = '{1'b0,   1'b0,  1'b0,  1'b0,   1'b1,  1'b1,   1'b1};
        int         tl [7] = '{50,     10,    2,     18,     2,     2,      2};
        int  lat;
        bit  tmo, ok;
        for (int i = 0; i < 7; i++) begin
            run8(tm[i], te[i], tn[i], lat, tmo, ok);
            checks++;
            if (tmo) begin errors++; $display("FAIL vec8[%0d] timeout: done never rose", i); end
            checks++;
            if (r8 !== tr[i] || err8 !== tx[i]) begin
                errors++;
                $display("FAIL vec8[%0d] result: r=%0d err=%b, want r=%0d err=%b", i, r8, err8, tr[i], tx[i]);
            end
            checks++;
            if (lat !== tl[i]) begin
                errors++;
                $display("FAIL vec8[%0d] latency: got %0d, want %0d", i, lat, tl[i]);
            end
        end
        // result and err hold in DONE
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (done8 !== 1'b1 || r8 !== 8'd0 || err8 !== 1'b1) begin
            errors++;
            $display("FAIL hold8: done=%b r=%0d err=%b, want 1/0/1", done8, r8, err8);
        end
    endtask

    task automatic test_busy_ignore8;
        int lat;
        m8 = 8'd4; e8 = 8'd13; n8 = 8'd253; s8 = 1'b1;
        @(posedge CLK); #1;
        s8 = 1'b0;
        lat = 1;
        repeat (5) begin @(posedge CLK); #1; lat++; end
        m8 = 8'd9; e8 = 8'd2; n8 = 8'd11; s8 = 1'b1;
        @(posedge CLK); #1;
        lat++;
        s8 = 1'b0;
        while (!done8 && lat < 3000) begin @(posedge CLK); #1; lat++; end
        checks++;
        if (r8 !== 8'd108 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore8 result: r=%0d err=%b, want 108/0", r8, err8);
        end
        checks++;
        if (lat !== 50) begin
            errors++;
            $display("FAIL busy_ignore8 latency: got %0d, want 50", lat);
        end
    endtask

    task automatic test_reset_mid_sqr8;
        int  lat;
        bit  tmo, ok, saw_done;
        m8 = 8'd4; e8 = 8'd13; n8 = 8'd253; s8 = 1'b1;
        @(posedge CLK); #1;
        s8 = 1'b0;
        // edges 3..10 are the first MUL, 11..18 the first SQR
        repeat (12) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checks++;
        if (r8 !== 8'd0 || done8 !== 1'b0 || busy8 !== 1'b0 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sqr8: r=%0d done=%b busy=%b err=%b, want all 0", r8, done8, busy8, err8);
        end
        saw_done = 1'b0;
        repeat (60) begin
            @(posedge CLK); #1;
            if (done8 || busy8) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_sqr8 quiet: done/busy=1 after abandon, want 0");
        end
        run8(8'd4, 8'd13, 8'd253, lat, tmo, ok);
        checks++;
        if (tmo || r8 !== 8'd108 || lat !== 50 || !ok) begin
            errors++;
            $display("FAIL reset_mid_sqr8 restart: r=%0d lat=%0d tmo=%b ok=%b, want 108/50/0/1", r8, lat, tmo, ok);
        end
    endtask

    initial begin
        RESET = 1'b1; s8 = 1'b0; s128 = 1'b0;
        m8 = '0; e8 = '0; n8 = '0;
        m128 = '0; e128 = '0; n128 = '0;
        test_reset();
        test_rsa128();
        test_vectors8();
        test_busy_ignore8();
        test_reset_mid_sqr8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter BITS, default 128, operand/result width in bits (legal BITS >= 4).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  request to begin one exponentiation on m, e, n.
REQ-005 SHALL have port m  input  BITS  message/base, unsigned.
REQ-006 SHALL have port e  input  BITS  exponent, unsigned.
REQ-007 SHALL have port n  input  BITS  modulus, unsigned.
REQ-008 SHALL have port r  output  BITS  result, m^e mod n.
REQ-009 SHALL have port done  output  1  level: r valid and stable.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port err  output  1  high with done when operands are illegal.

Function
REQ-012 SHALL use states IDLE, CHECK, MUL, SQR, DONE.
REQ-013 SHALL sample START only in IDLE or DONE; START in CHECK/MUL/SQR SHALL be ignored.
REQ-014 On START sampled, SHALL copy m, e, n into internal registers in that cycle, enter CHECK, drop done/err, raise busy; later changes on m/e/n SHALL not affect the operation.
REQ-015 CHECK (1 cycle): if n <= 1 or m >= n, SHALL enter DONE with r = 0, err = 1.
REQ-016 CHECK: if e == 0 (legal operands), SHALL enter DONE with r = 1, err = 0.
REQ-017 Otherwise SHALL set acc = 1, base = m, and run right-to-left square-and-multiply over the captured exponent, LSB first.
REQ-018 Per exponent bit: if bit = 1, MUL computes acc = acc*base mod n; then, if the remaining exponent (shifted right by one) is zero, SHALL enter DONE with r = acc; else SQR computes base = base*base mod n, shifts exponent right, repeats.
REQ-019 Each modular multiply SHALL be interleaved shift-add, MSB-first over the multiplier, exactly BITS cycles, one bit per cycle.
REQ-020 Per multiply cycle: P <= 2P + (bit ? b : 0), then subtract n at most twice so P < n; P SHALL be BITS+2 bits wide, no overflow.
REQ-021 State transitions out of MUL/SQR SHALL occur on the last multiply cycle, no idle cycles between multiplies.
REQ-022 Latency: done SHALL rise 2 + BITS*(popcount(e) + floor(log2 e)) cycles after the START edge for e > 0; 2 cycles for e == 0 or illegal operands.
REQ-023 In DONE: done = 1, busy = 0, r and err held until RESET or a new START is sampled.
REQ-024 START sampled in DONE SHALL start a new operation; done SHALL fall on that edge.
REQ-025 r SHALL only change on entry to DONE or on reset; intermediate values SHALL not appear on r.

Reset
REQ-026 RESET high at an edge SHALL force IDLE, r = 0, done = 0, busy = 0, err = 0, regardless of state.
REQ-027 RESET SHALL dominate START in the same cycle.
REQ-028 RESET mid-operation SHALL abandon it; no done pulse SHALL follow; next START runs normally.

Verification
REQ-029 BITS=128, m=65, e=17, n=3233, START 1 cycle -> r=2790, done=1, err=0, done at cycle 2+128*(2+4)=770.
REQ-030 BITS=128, m=2790, e=2753, n=3233 -> r=65, err=0; then m=0, e=5 -> r=0.
REQ-031 BITS=8, m=4, e=13, n=253 -> r=108 after 2+8*(3+3)=50 cycles; e=1 -> r=4 after 10 cycles; e=0 -> r=1 after 2 cycles.
REQ-032 BITS=8, n=1 or m=253 with n=253 -> done after 2 cycles, r=0, err=1.
REQ-033 START re-pulsed and m/e/n changed while busy -> ignored; result matches originally captured operands.
REQ-034 RESET asserted mid-SQR -> next cycle r=0, done=0, busy=0; no done until a new START; new START yields correct result.
